// File: rtl/rf_wport_sched.sv
// Register-file write-port scheduler: WB has priority, MDU results queue in a
// small FIFO, and a per-register pending scoreboard stalls decode on hazards.
module rf_wport_sched #(
    parameter int DW      = 32,
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [4:0]    wb_rw,
    input  logic [DW-1:0] wb_din,
    input  logic          mdu_valid,
    input  logic [4:0]    mdu_rw,
    input  logic [DW-1:0] mdu_din,
    output logic          mdu_ready,
    input  logic          iss_valid,
    input  logic [4:0]    iss_rd,
    output logic          iss_ready,
    input  logic [4:0]    id_ra,
    input  logic [4:0]    id_rb,
    input  logic [4:0]    id_rd,
    output logic          stall,
    output logic          rf_we,
    output logic [4:0]    rf_rw,
    output logic [DW-1:0] rf_din
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam logic [FCW-1:0] DEPTH_C = FCW'(DEPTH);
    localparam logic [CW-1:0]  MAX_C   = CW'(MAX_OUT);

    typedef struct packed {
        logic [4:0]    rw;
        logic [DW-1:0] data;
    } ent_t;

    ent_t           mem [DEPTH];
    ent_t           head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [FCW-1:0] count;
    logic [31:0]    pending;
    logic [CW-1:0]  out_cnt;

    logic        wb_own, fifo_ne, push, pop, iss_fire, hazard;
    logic [31:0] set_mask, clr_mask;

    assign head = mem[rd_ptr];

    // All state-derived outputs are forced to their reset values while rst is
    // held, so nothing buffered before the reset can leak onto the port.
    always_comb begin
        wb_own    = !rst && wb_we && (wb_rw != 5'd0);
        fifo_ne   = !rst && (count != '0);
        pop       = !wb_own && fifo_ne;
        mdu_ready = rst || (count < DEPTH_C);
        iss_ready = rst || (out_cnt < MAX_C);
        push      = mdu_valid && mdu_ready;

        hazard = ((id_ra != 5'd0) && pending[id_ra]) ||
                 ((id_rb != 5'd0) && pending[id_rb]) ||
                 ((id_rd != 5'd0) && pending[id_rd]);
        stall    = (!rst && hazard) || (iss_valid && !iss_ready);
        iss_fire = iss_valid && iss_ready && !stall;

        set_mask = '0;
        clr_mask = '0;
        if (iss_fire && (iss_rd != 5'd0))
            set_mask[iss_rd] = 1'b1;
        if (pop)
            clr_mask[head.rw] = 1'b1;
    end

    always_comb begin
        rf_we  = 1'b0;
        rf_rw  = 5'd0;
        rf_din = '0;
        if (wb_own) begin
            rf_we  = 1'b1;
            rf_rw  = wb_rw;
            rf_din = wb_din;
        end else if (pop) begin
            // r0 entries still consume a pop but never assert the write strobe
            rf_we  = (head.rw != 5'd0);
            rf_rw  = head.rw;
            rf_din = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= '{rw: mdu_rw, data: mdu_din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pending <= '0;
            out_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + FCW'(1);
                2'b01:   count <= count - FCW'(1);
                default: count <= count;
            endcase
            // set is applied after clear so a same-cycle reissue wins
            pending <= (pending & ~clr_mask) | set_mask;
            case ({iss_fire, pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: doc/rf_wport_sched.md
Name: rf_wport_sched

Overview:
- Write-port scheduler and scoreboard in front of the 32x32 register file (one write port, write on negedge clk, writes to r0 ignored).
- Arbitrates the single write port between the in-order pipeline WB stage and the multi-cycle multiply/divide unit (MDU), buffering MDU results in a small FIFO.
- Tracks destination registers of in-flight MDU ops and raises a decode-stage stall on RAW/WAW hazards against them.

Parameters:
DW, 32, data width of write-port payload
DEPTH, 2, MDU result FIFO entries (power of two, >=2)
MAX_OUT, 4, maximum MDU ops in flight (issued, not yet written to regfile)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
wb_we  in  1  pipeline WB write request (never back-pressured)
wb_rw  in  5  WB destination register
wb_din  in  DW  WB write data
mdu_valid  in  1  MDU result valid
mdu_rw  in  5  MDU result destination
mdu_din  in  DW  MDU result data
mdu_ready  out  1  FIFO can accept MDU result
iss_valid  in  1  decode issues an MDU op this cycle
iss_rd  in  5  destination of issued MDU op
iss_ready  out  1  in-flight count below MAX_OUT
id_ra  in  5  decode source register A
id_rb  in  5  decode source register B
id_rd  in  5  decode destination register
stall  out  1  decode must hold
rf_we  out  1  regfile write enable
rf_rw  out  5  regfile write address
rf_din  out  DW  regfile write data

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. While rst=1 and on the cycle after: FIFO empty, pending[31:0]=0, out_cnt=0; hence rf_we=0, rf_rw=0, rf_din=0, stall=0, mdu_ready=1, iss_ready=1. Reset mid-operation discards buffered MDU results and all pending bits.
- Arbitration, combinational from current state and inputs:
  - wb_we=1 and wb_rw!=0: WB owns the port; rf_we=1, rf_rw=wb_rw, rf_din=wb_din.
  - Otherwise, FIFO non-empty: head owns the port; rf_we=1, rf_rw=head.rw, rf_din=head.data; pop at posedge.
  - Otherwise: rf_we=0, rf_rw=0, rf_din=0.
- WB always has priority. A WB request with wb_rw=0 does not block the FIFO.
- FIFO:
  - mdu_ready = (count < DEPTH), registered-state only; no same-cycle pass-through.
  - Push when mdu_valid & mdu_ready.
  - Push and pop in the same cycle: count unchanged.
  - Minimum latency from MDU accept to regfile write: 1 cycle.
  - Entries with mdu_rw=0 are accepted, popped when they win the port, and drive rf_we=0.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - iss_valid & iss_ready & !stall & iss_rd!=0: sets pending[iss_rd] and increments out_cnt.
  - iss_rd=0: increments out_cnt only.
  - Each FIFO pop decrements out_cnt and clears pending[head.rw].
  - Same-cycle set and clear of the same register: set wins.
  - Same-cycle increment and decrement: out_cnt unchanged.
  - iss_ready = (out_cnt < MAX_OUT). out_cnt width is clog2(MAX_OUT+1).
- Stall (combinational): stall = (id_ra!=0 & pending[id_ra]) | (id_rb!=0 & pending[id_rb]) | (id_rd!=0 & pending[id_rd]) | (iss_valid & !iss_ready).
  - Because WAW is stalled, at most one in-flight op targets any register, so one pending bit per register suffices.
- A pending bit clears on the same posedge as the popping write. stall drops the next cycle, so decode reads the value written at that cycle's negedge.
- Illegal (assertion in bench, no RTL handling): mdu_valid with out_cnt=0.

Test Plan:
- Reset with rst=1 for 2 cycles mid-traffic (FIFO holding 2 entries, pending[5]=1) -> cycle after release: rf_we=0, stall=0 for id_ra=5, mdu_ready=1, iss_ready=1, and no stale entry is ever written.
- Issue MDU op to r8, then id_ra=8 -> stall=1. mdu_valid with rw=8, din=0x0000_00FF while wb_we=0 -> next cycle rf_we=1, rf_rw=8, rf_din=0xFF; stall=0 the following cycle.
- Contention: FIFO holds {r3:0x11}. wb_we=1 with wb_rw=4, din=0x22 for 3 cycles -> rf_rw=4 for 3 cycles, then rf_rw=3, rf_din=0x11. pending[3] stays 1 until that cycle.
- FIFO full: DEPTH=2 entries buffered under continuous WB -> mdu_ready=0, held mdu_valid is not lost. Once WB idles, drain is in order: entry0, entry1, then the held result.
- Limit: 4 issues to r1..r4 -> iss_ready=0 and stall=1 on a 5th iss_valid. One pop -> iss_ready=1.
- r0 handling: issue iss_rd=0 and MDU result rw=0, din=0xDEAD -> out_cnt increments then returns to 0, pending unchanged, rf_we never 1 for that entry, and a concurrent wb_rw=0 request does not block the pop.
